alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width (must match the ALU datapath width).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports: req_valid  input  2  per-requester request strobe, bit i = requester i.
REQ-005 SHALL have ports: req0_srca, req0_srcb, req1_srca, req1_srcb  input  DATA_W each  operands.
REQ-006 SHALL have ports: req0_alucontrol, req1_alucontrol  input  3 each  ALU opcode.
REQ-007 SHALL have port: req_ready  output  2  request accepted this cycle (one-hot or zero).
REQ-008 SHALL have ports: alu_srca, alu_srcb  output  DATA_W; alu_alucontrol  output  3  drive to the shared ALU.
REQ-009 SHALL have ports: alu_aluout  input  DATA_W; alu_zero  input  1  combinational ALU results.
REQ-010 SHALL have ports: rsp_valid  output  1; rsp_id  output  1; rsp_data  output  DATA_W; rsp_zero  output  1; rsp_ready  input  1.

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-012 In IDLE with any req_valid set, SHALL grant one requester per policy, assert its req_ready that cycle, latch its operands/opcode into the ALU drive registers, record rsp_id, and go to EXEC.
REQ-013 In IDLE with req_valid == 0, SHALL hold state and keep req_ready = 0.
REQ-014 In EXEC, SHALL capture alu_aluout and alu_zero into rsp_data and rsp_zero, and go to RESP.
REQ-015 In RESP, SHALL assert rsp_valid and hold rsp_id, rsp_data, rsp_zero stable until rsp_ready = 1; on that cycle it SHALL return to IDLE.
REQ-016 Latency SHALL be: accepted at cycle N, rsp_valid high at cycle N+2; best-case throughput is one op per 3 cycles.
REQ-017 req_ready SHALL be 0 in EXEC and RESP; no new request is accepted before the prior response handshake completes.
REQ-018 alu_srca, alu_srcb, alu_alucontrol SHALL be registered and hold their last granted values between operations.
REQ-019 The default policy SHALL be round-robin: a pointer names the favoured requester; after each completed response the pointer SHALL move to the requester not just served.
REQ-020 If only one requester is valid, it SHALL be granted regardless of the pointer.
REQ-021 A requester that deasserts req_valid before being granted SHALL lose its request; no response is generated for it.

Reset
REQ-022 While reset_n = 0 at a clk edge, the block SHALL enter IDLE and set the RR pointer to requester 0.
REQ-023 Reset SHALL drive to 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, alu_srca, alu_srcb, alu_alucontrol.
REQ-024 Reset during EXEC or RESP SHALL abandon the transaction, and no rsp_valid SHALL follow it.

Configuration
REQ-025 With macro ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win when both are valid, and the RR pointer SHALL be omitted.
REQ-026 Without ALU_ARB_FIXED_PRIO_EN, the round-robin policy of REQ-019 SHALL apply.

Structure
REQ-027 Shared package alu_arb_pkg SHALL hold: the FSM state enum (IDLE, EXEC, RESP) and ALU opcode constants AND=000, OR=001, ADD=010, SUB=110, SLT=111.
REQ-028 Grant selection SHALL live in sub-module alu_arb_grant: inputs req_valid and pointer; output one-hot grant; pure combinational.
REQ-029 alu_arbiter SHALL NOT instantiate the ALU; the ALU connects externally via the alu_* ports.

Verification
REQ-030 Single op: req0 ADD, 5 + 7, accepted at cycle N -> rsp_valid at N+2 with rsp_id = 0, rsp_data = 12, rsp_zero = 0.
REQ-031 Zero flag: req1 SUB, 9 - 9 -> rsp_data = 0, rsp_zero = 1, rsp_id = 1; SLT, 0xFFFFFFFF < 3 -> rsp_data = 1.
REQ-032 Contention: both requesters continuously valid after reset -> grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN defined -> 0,0,0,0.
REQ-033 Backpressure: rsp_ready low for 4 cycles in RESP -> rsp_data, rsp_id, rsp_zero unchanged; req_ready stays 0; accept occurs the cycle after rsp_ready rises.
REQ-034 Reset mid-op: reset_n low for 1 cycle during EXEC -> no rsp_valid; all outputs 0; next request served as requester 0 first.
REQ-035 Withdrawn request: req1 valid for 1 cycle while in RESP, then low -> req1 is never granted and no response carries rsp_id = 1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Consumed by alu_arbiter and alu_arb_grant.
package alu_arb_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [OP_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_arb_grant.sv
// Combinational grant select: a lone requester always wins,
// and on contention the pointer names the winner.
module alu_arb_grant
  import alu_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req0_srca,
  input  logic [DATA_W-1:0] req0_srcb,
  input  logic [DATA_W-1:0] req1_srca,
  input  logic [DATA_W-1:0] req1_srcb,
  input  logic [OP_W-1:0]   req0_alucontrol,
  input  logic [OP_W-1:0]   req1_alucontrol,
  output logic [1:0]        req_ready,
  output logic [DATA_W-1:0] alu_srca,
  output logic [DATA_W-1:0] alu_srcb,
  output logic [OP_W-1:0]   alu_alucontrol,
  input  logic [DATA_W-1:0] alu_aluout,
  input  logic              alu_zero,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  input  logic              rsp_ready
);

  localparam logic [STATE_W-1:0] S_IDLE = IDLE;
  localparam logic [STATE_W-1:0] S_EXEC = EXEC;
  localparam logic [STATE_W-1:0] S_RESP = RESP;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [1:0]         grant;
  logic               ptr;
  logic               accept;
  logic               rsp_done;

  alu_arb_grant u_grant (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant)
  );

  assign accept   = (state == S_IDLE) && (grant != 2'b00);
  assign rsp_done = (state == S_RESP) && rsp_ready;

  // Acceptance is signalled in the same cycle the grant is taken.
  always_comb begin
    req_ready = 2'b00;
    if (state == S_IDLE) req_ready = grant;
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr = 1'b0;
`else
  // Favour the requester that was not just served.
  always_ff @(posedge clk) begin
    if (!reset_n)      ptr <= 1'b0;
    else if (rsp_done) ptr <= ~rsp_id;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)    state_nxt = S_EXEC;
      S_EXEC:                 state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // ALU drive registers hold the last granted operation between requests.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alu_srca       <= '0;
      alu_srcb       <= '0;
      alu_alucontrol <= '0;
      rsp_id         <= 1'b0;
    end else if (accept) begin
      alu_srca       <= grant[1] ? req1_srca : req0_srca;
      alu_srcb       <= grant[1] ? req1_srcb : req0_srcb;
      alu_alucontrol <= grant[1] ? req1_alucontrol : req0_alucontrol;
      rsp_id         <= grant[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else if (state == S_EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_aluout;
      rsp_zero  <= alu_zero;
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the alu_* ports.
// Honours ALU_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              reset_n;
  logic [1:0]        req_valid;
  logic [DATA_W-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [2:0]        req0_alucontrol, req1_alucontrol;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] alu_srca, alu_srcb;
  logic [2:0]        alu_alucontrol;
  logic [DATA_W-1:0] alu_aluout;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_ready;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req0_srca       (req0_srca),
    .req0_srcb       (req0_srcb),
    .req1_srca       (req1_srca),
    .req1_srcb       (req1_srcb),
    .req0_alucontrol (req0_alucontrol),
    .req1_alucontrol (req1_alucontrol),
    .req_ready       (req_ready),
    .alu_srca        (alu_srca),
    .alu_srcb        (alu_srcb),
    .alu_alucontrol  (alu_alucontrol),
    .alu_aluout      (alu_aluout),
    .alu_zero        (alu_zero),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_data        (rsp_data),
    .rsp_zero        (rsp_zero),
    .rsp_ready       (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External single-cycle ALU
  always_comb begin
    alu_aluout = '0;
    case (alu_alucontrol)
      ALU_AND: alu_aluout = alu_srca & alu_srcb;
      ALU_OR:  alu_aluout = alu_srca | alu_srcb;
      ALU_ADD: alu_aluout = alu_srca + alu_srcb;
      ALU_SUB: alu_aluout = alu_srca - alu_srcb;
      ALU_SLT: alu_aluout = ($signed(alu_srca) < $signed(alu_srcb)) ? 32'd1 : 32'd0;
      default: alu_aluout = '0;
    endcase
    alu_zero = (alu_aluout == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_rsp_data"},  rsp_data,       32'd0);
    chk({tag, "_rsp_zero"},  32'(rsp_zero),  32'd0);
    chk({tag, "_alu_srca"},  alu_srca,       32'd0);
    chk({tag, "_alu_srcb"},  alu_srcb,       32'd0);
    chk({tag, "_alu_ctl"},   32'(alu_alucontrol), 32'd0);
  endtask

  logic [1:0]  exp_grant;
  logic [31:0] exp_data;

  initial begin
    reset_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req0_srca = '0; req0_srcb = '0; req0_alucontrol = '0;
    req1_srca = '0; req1_srcb = '0; req1_alucontrol = '0;
    tick();
    tick();
    chk_all_zero("reset");

    // Single op: req0 ADD 5+7
    reset_n = 1'b1;
    tick();
    req_valid = 2'b01; req0_srca = 32'd5; req0_srcb = 32'd7; req0_alucontrol = ALU_ADD;
    settle();
    chk("add_accept_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    settle();
    chk("add_exec_ready", 32'(req_ready), 32'd0);
    chk("add_exec_valid", 32'(rsp_valid), 32'd0);
    chk("add_exec_srca", alu_srca, 32'd5);
    chk("add_exec_ctl", 32'(alu_alucontrol), 32'(ALU_ADD));
    tick();
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_rsp_id", 32'(rsp_id), 32'd0);
    chk("add_rsp_data", rsp_data, 32'd12);
    chk("add_rsp_zero", 32'(rsp_zero), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("add_done_valid", 32'(rsp_valid), 32'd0);
    chk("add_hold_srca", alu_srca, 32'd5);

    // req1 SUB 9-9 sets zero
    req_valid = 2'b10; req1_srca = 32'd9; req1_srcb = 32'd9; req1_alucontrol = ALU_SUB;
    settle();
    chk("sub_accept_ready", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    tick();
    chk("sub_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sub_rsp_id", 32'(rsp_id), 32'd1);
    chk("sub_rsp_data", rsp_data, 32'd0);
    chk("sub_rsp_zero", 32'(rsp_zero), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // req0 SLT: -1 < 3 signed
    req_valid = 2'b01; req0_srca = 32'hFFFF_FFFF; req0_srcb = 32'd3; req0_alucontrol = ALU_SLT;
    settle();
    chk("slt_accept_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
    chk("slt_rsp_data", rsp_data, 32'd1);
    chk("slt_rsp_zero", 32'(rsp_zero), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset for one cycle while in EXEC abandons the op
    req_valid = 2'b10; req1_srca = 32'd4; req1_srcb = 32'd2; req1_alucontrol = ALU_ADD;
    settle();
    chk("rst_accept_ready", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_all_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Contention: both valid continuously, response accepted immediately
    req0_srca = 32'd1;  req0_srcb = 32'd1; req0_alucontrol = ALU_ADD;
    req1_srca = 32'd10; req1_srcb = 32'd3; req1_alucontrol = ALU_SUB;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_grant = 2'b01;
`else
      exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      exp_data = exp_grant[1] ? 32'd7 : 32'd2;
      settle();
      chk($sformatf("cont%0d_ready", i), 32'(req_ready), 32'(exp_grant));
      tick();
      chk($sformatf("cont%0d_exec_ready", i), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("cont%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("cont%0d_rsp_id", i), 32'(rsp_id), 32'(exp_grant[1]));
      chk($sformatf("cont%0d_rsp_data", i), rsp_data, exp_data);
      tick();
    end

    // Backpressure: rsp_ready low for 4 cycles in RESP
    rsp_ready = 1'b0;
    req_valid = 2'b01; req0_srca = 32'hF0; req0_srcb = 32'h0F; req0_alucontrol = ALU_OR;
    settle();
    chk("bp_accept_ready", 32'(req_ready), 32'd1);
    tick();
    tick();
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rsp_data", rsp_data, 32'hFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_data", i), rsp_data, 32'hFF);
      chk($sformatf("bp%0d_id", i), 32'(rsp_id), 32'd0);
      chk($sformatf("bp%0d_zero", i), 32'(rsp_zero), 32'd0);
    end
    rsp_ready = 1'b1;
    req0_alucontrol = ALU_AND;
    settle();
    chk("bp_release_ready", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    settle();
    chk("bp_next_accept", 32'(req_ready), 32'd1);
    chk("bp_next_valid", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = 2'b00;
    tick();
    chk("and_rsp_data", rsp_data, 32'd0);
    chk("and_rsp_zero", 32'(rsp_zero), 32'd1);

    // Withdrawn request: req1 raised for one cycle during RESP
    req_valid = 2'b10;
    settle();
    chk("wd_ready_in_resp", 32'(req_ready), 32'd0);
    tick();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wd%0d_ready", i), 32'(req_ready), 32'd0);
      chk($sformatf("wd%0d_valid", i), 32'(rsp_valid), 32'd0);
      tick();
    end
    chk("wd_last_id", 32'(rsp_id), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
